// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost thresholds and a
// standard or first-word-fall-through read mode. Define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         rd,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         full,
    output logic                         almost_full,
    output logic                         mty,
    output logic                         almost_mty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         next_count;
    logic                  wr_acc;
    logic                  rd_acc;

    // full is checked before the read, so a full FIFO drops a write even when a read pops.
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~mty;

    always_comb begin
        next_count = count;
        if (wr_acc && !rd_acc)
            next_count = count + CW'(1);
        else if (!wr_acc && rd_acc)
            next_count = count - CW'(1);
    end

    // NOTE: storage has no reset; count and the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            mty         <= 1'b1;
            almost_mty  <= 1'b1;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            count       <= next_count;
            full        <= (next_count == CW'(DEPTH));
            almost_full <= (next_count >= CW'(AF_LEVEL));
            mty         <= (next_count == '0);
            almost_mty  <= (next_count <= CW'(AE_LEVEL));
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; rd only acknowledges it.
            assign q = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] q_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    q_reg <= '0;
                else if (rd_acc)
                    q_reg <= mem[rd_ptr];
            end

            assign q = q_reg;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // A set on the same edge as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;

            if (rd && mty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-read and an FWFT instance share
// stimulus; a queue model predicts contents, flags and read data.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] data;

    logic [DW-1:0] q_s, q_f;
    logic          full_s, af_s, mty_s, ae_s;
    logic          full_f, af_f, mty_f, ae_f;
    logic [CW-1:0] count_s, count_f;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          ovf_s, udf_s, ovf_f, udf_f;
    bit            m_ovf, m_udf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr(wr), .data(data), .rd(rd), .q(q_s),
        .full(full_s), .almost_full(af_s), .mty(mty_s), .almost_mty(ae_s), .count(count_s)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr), .overflow(ovf_s), .underflow(udf_s)
`endif
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr(wr), .data(data), .rd(rd), .q(q_f),
        .full(full_f), .almost_full(af_f), .mty(mty_f), .almost_mty(ae_f), .count(count_f)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr), .overflow(ovf_f), .underflow(udf_f)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue; popped words go to the scoreboard.
    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        int  n;
        bit  do_w, do_r;
        if (rst) begin
            model.delete();
            exp_q.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            m_ovf = 1'b0;
            m_udf = 1'b0;
`endif
        end else begin
            n    = model.size();
            do_w = wr && (n < DEPTH);
            do_r = rd && (n > 0);
            if (do_r)
                exp_q.push_back(model.pop_front());
            if (do_w)
                model.push_back(data);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (wr && n == DEPTH)  m_ovf = 1'b1;
            else if (err_clr)      m_ovf = 1'b0;
            if (rd && n == 0)      m_udf = 1'b1;
            else if (err_clr)      m_udf = 1'b0;
`endif
        end
    end

    // Monitor: compares outputs on the falling edge, away from the active edge.
    logic [DW-1:0] q_hold;

    always @(negedge clk) begin
        int n;
        if (rst) begin
            q_hold = '0;
        end else begin
            n = model.size();
            if (exp_q.size() > 0)
                q_hold = exp_q.pop_front();
            check("q_std", q_s, q_hold);
            if (n > 0)
                check("q_fwft", q_f, model[0]);
            check("count", count_s, n);
            check("mty", mty_s, n == 0);
            check("almost_mty", ae_s, n <= 2);
            check("full", full_s, n == DEPTH);
            check("almost_full", af_s, n >= DEPTH - 2);
            check("count_fwft", count_f, n);
            check("mty_fwft", mty_f, n == 0);
            check("full_fwft", full_f, n == DEPTH);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check("overflow", ovf_s, m_ovf);
            check("underflow", udf_s, m_udf);
            check("overflow_fwft", ovf_f, m_ovf);
            check("underflow_fwft", udf_f, m_udf);
`endif
        end
    end

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
        wr   = w;
        rd   = r;
        data = d;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = clr;
`else
        if (clr) data = d;
`endif
        @(posedge clk);
        #2;
        wr = 1'b0;
        rd = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic drain();
        while (model.size() > 0)
            step(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        int pw, pr;
        rst  = 1'b1;
        wr   = 1'b0;
        rd   = 1'b0;
        data = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_mty", mty_s, 1'b1);
        check("rst_almost_mty", ae_s, 1'b1);
        check("rst_full", full_s, 1'b0);
        check("rst_almost_full", af_s, 1'b0);
        check("rst_count", count_s, 0);
        check("rst_q", q_s, 0);

        // Fill with 0x01..0x10 and watch the upper thresholds.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), 1'b0);
            if (i == 13) check("af_at_13", af_s, 1'b0);
            if (i == 14) check("af_at_14", af_s, 1'b1);
            if (i == 15) check("full_at_15", full_s, 1'b0);
        end
        check("full_at_16", full_s, 1'b1);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        check("drop_when_full", count_s, 16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("ovf_set", ovf_s, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", ovf_s, 1'b0);
`endif
        drain();
        check("drained", mty_s, 1'b1);

        // Pointer wrap with occupancy held at 3.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, DW'($urandom), 1'b0);
            check("wrap_count", count_s, 3);
        end
        drain();

        // Full with simultaneous wr+rd: read wins, write dropped.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'hBB, 1'b0);
        check("full_wr_rd", count_s, 15);
        drain();

        // Empty with simultaneous wr+rd: write wins, read ignored.
        step(1'b1, 1'b1, 8'hCC, 1'b0);
        check("empty_wr_rd", count_s, 1);
        drain();

        // FWFT: head word visible one cycle after the write, no rd needed.
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        check("fwft_mty", mty_f, 1'b0);
        check("fwft_q", q_f, 8'h5A);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_pop", mty_f, 1'b1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("udf_set", udf_s, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("udf_sticky", udf_s, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("udf_clr", udf_s, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("udf_set_wins", udf_s, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // Mid-stream reset while full with a pending error flag.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_count", count_s, 0);
        check("mid_rst_mty", mty_s, 1'b1);
        check("mid_rst_almost_mty", ae_s, 1'b1);
        check("mid_rst_full", full_s, 1'b0);
        check("mid_rst_almost_full", af_s, 1'b0);
        check("mid_rst_q", q_s, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("mid_rst_ovf", ovf_s, 1'b0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 1'b0, 8'h77, 1'b0);
        check("first_write_entry0", u_std.mem[0], 8'h77);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Randomised traffic in phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 400; i++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     DW'($urandom), $urandom_range(0, 15) == 0);
        end
        drain();
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised synchronous FIFO. Generalises the existing fifo_if signal set (wr/rd/data/q, full/almost_full, mty/almost_mty) with configurable width and depth, programmable almost thresholds, an occupancy count, and a selectable read mode: standard registered read or first-word-fall-through (FWFT). It sits between AXI-stream style producers and consumers inside a single clock domain.

Parameters:
DATA_WIDTH, 8, width of data and q.
DEPTH, 16, number of entries; power of 2, >= 2.
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 2, almost_mty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
wr  input  1  write request.
data  input  DATA_WIDTH  write data, sampled when a write is accepted.
rd  input  1  read request.
q  output  DATA_WIDTH  read data.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_LEVEL.
mty  output  1  count == 0.
almost_mty  output  1  count <= AE_LEVEL.
count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert, sync release) forces:
  - wr_ptr = 0, rd_ptr = 0, count = 0, q = 0.
  - mty = 1, almost_mty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after release lands in entry 0.
- Accept rules, evaluated on the rising edge:
  - wr_acc = wr & !full.
  - rd_acc = rd & !mty.
  - wr while full: dropped, no state change.
  - rd while mty: ignored, q holds its value.
- Simultaneous accepted wr and rd:
  - count is unchanged; both pointers advance.
  - When full with wr and rd both high: the read is accepted and the write is dropped (full is evaluated before the read).
  - When empty with wr and rd both high: the write is accepted and the read is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update: count + wr_acc - rd_acc.
- All flags are registered and derived from next-count, so each flag is valid in the cycle after the accepted access that changes it.
  - Example: one write into an empty FIFO drops mty on the next edge.
- FWFT=0 (standard read):
  - q is registered: q <= mem[rd_ptr] on rd_acc.
  - Read latency is 1 cycle: data is valid on q the cycle after rd is sampled high with mty low.
- FWFT=1 (first-word-fall-through):
  - q = mem[rd_ptr] combinationally, valid whenever mty = 0.
  - rd acts as an acknowledge that pops the head entry.
  - Write-to-q latency is 1 cycle (the memory write plus the mty update).
  - q is don't-care while mty = 1.
- Memory is a write-first register array. A simultaneous write and read to different addresses never conflict because count prevents pointer aliasing except when full or empty.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds three ports.
  - err_clr  input  1: synchronous clear.
  - overflow  output  1: sticky; sets on the edge where wr & full.
  - underflow  output  1: sticky; sets on the edge where rd & mty.
  - Both flags reset to 0 and clear on err_clr. If set and clear coincide, set wins.
  - The simultaneous full wr+rd case still sets overflow, because the write is dropped.
- Undefined: none of these ports or registers exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> mty=1, almost_mty=1, full=0, almost_full=0, count=0, q=0.
- FWFT=0, DEPTH=16: write 0x01..0x10 on consecutive cycles.
  - Response: full=1 one cycle after the 16th write; almost_full=1 after the 14th write.
  - An extra write of 0xAA is dropped; count stays 16.
  - Reading 16 times returns 0x01..0x10 in order, each 1 cycle after its rd.
- Pointer wrap: run 40 interleaved write/read pairs with count kept at 3 -> data order preserved and count constant at 3.
- Full with wr and rd in the same cycle -> count goes 16->15 and the write is dropped. Empty with wr and rd in the same cycle -> count goes 0->1 and the read is ignored.
- FWFT=1: write 0x5A into an empty FIFO -> mty=0 and q=0x5A on the next cycle with no rd. One rd cycle -> mty=1.
- SYNC_FIFO_ERR_FLAGS_EN:
  - rd while empty -> underflow=1 and stays 1; err_clr pulse -> underflow=0.
  - wr while full -> overflow=1.
  - Mid-stream reset -> all flags return to reset values within the same cycle.
